// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU operand issue stage.
// Holds the issue FSM state encoding and the datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/mux32.sv
// 32-bit two-way select mux built from NAND terms.
// Ports: in0/in1 operands, sel picks in1 when high, mux_out result.
import alu_pkg::*;

module mux32 (
  input  logic [ALU_WIDTH-1:0] in0,
  input  logic [ALU_WIDTH-1:0] in1,
  input  logic                 sel,
  output logic [ALU_WIDTH-1:0] mux_out
);

  logic [ALU_WIDTH-1:0] sel_v;
  logic [ALU_WIDTH-1:0] n0;
  logic [ALU_WIDTH-1:0] n1;

  assign sel_v   = {ALU_WIDTH{sel}};
  assign n0      = ~(in0 & ~sel_v);
  assign n1      = ~(in1 & sel_v);
  assign mux_out = ~(n0 & n1);

endmodule

// File: rtl/alu_operand_issue.sv
// Issue stage: freezes operands into mux32, waits SETTLE_CYCLES, captures.
// Ports: in_* upstream handshake + operands, out_* result handshake, busy.
import alu_pkg::*;

module alu_operand_issue #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALU_WIDTH-1:0] in0,
  input  logic [ALU_WIDTH-1:0] in1,
  input  logic                 sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_WIDTH-1:0] out_data,
  output logic                 busy
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(SETTLE_CYCLES - 1);

  issue_state_t         state;
  logic [CW-1:0]        cnt;
  logic [ALU_WIDTH-1:0] r_in0;
  logic [ALU_WIDTH-1:0] r_in1;
  logic                 r_sel;
  logic [ALU_WIDTH-1:0] mux_out;
  logic                 accept;

  mux32 u_mux (
    .in0     (r_in0),
    .in1     (r_in1),
    .sel     (r_sel),
    .mux_out (mux_out)
  );

  // out_ready -> in_ready is combinational so a
  // result drain and a new load share one edge.
  assign in_ready  = (state == IDLE) |
                     ((state == HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      r_in0    <= '0;
      r_in1    <= '0;
      r_sel    <= 1'b0;
      out_data <= '0;
    end else begin
      if (accept) begin
        r_in0 <= in0;
        r_in1 <= in1;
        r_sel <= sel;
        cnt   <= CNT_LOAD;
        state <= SETTLE;
      end else begin
        unique case (state)
          IDLE: ;
          SETTLE: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              out_data <= mux_out;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (out_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Randomized bench for alu_operand_issue against a timestamp model.
// Model: a pair accepted at edge a is visible from edge a+SC until drained.
module tb_alu_operand_issue;

  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // transaction-level reference state
  int          m_edge = 0;
  bit          m_inflight = 0;
  int          m_acc = 0;
  logic [31:0] m_val = '0;
  logic [31:0] m_data = '0;

  always #25 clk = ~clk;

  alu_operand_issue #(.SETTLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // one clock: drive, compare mid-cycle, advance model at the edge
  task automatic step(input bit iv,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input bit s,
                      input bit ordy,
                      input bit rn);
    bit ov;
    bit ir;
    rst_n     = rn;
    in_valid  = iv;
    in0       = a;
    in1       = b;
    sel       = s;
    out_ready = ordy;
    ov = m_inflight && (m_edge >= m_acc + SC);
    ir = !m_inflight || (ov && ordy);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("in_ready", 32'(in_ready), 32'(ir));
    chk("busy", 32'(busy), 32'(m_inflight));
    chk("out_data", out_data, m_data);
    @(posedge clk);
    m_edge++;
    if (!rn) begin
      m_inflight = 0;
      m_data     = '0;
    end else begin
      if (m_inflight && !ov && m_edge == m_acc + SC)
        m_data = m_val;
      if (ov && ordy) m_inflight = 0;
      if (iv && ir) begin
        m_inflight = 1;
        m_acc      = m_edge;
        m_val      = s ? b : a;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in0 = '0;
    in1 = '0; sel = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    m_edge++;

    // reset held with in_valid asserted
    step(1, 32'hAAAA5555, 32'h5555AAAA, 1, 0, 0);
    step(1, 32'hAAAA5555, 32'h5555AAAA, 1, 0, 0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd1);

    // single op, sel=1 then sel=0
    step(1, 32'hDEADBEEF, 32'h12345678, 1, 1, 1);
    step(0, '0, '0, 0, 0, 1);
    chk("lat_early", 32'(out_valid), 32'd0);
    step(0, '0, '0, 0, 0, 1);
    chk("single1_ov", 32'(out_valid), 32'd1);
    chk("single1", out_data, 32'h12345678);
    step(1, 32'hDEADBEEF, 32'h12345678, 0, 1, 1);
    step(0, '0, '0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 1);
    chk("single0", out_data, 32'hDEADBEEF);

    // backpressure in HOLD, then drain+accept on one edge
    for (int i = 0; i < 5; i++)
      step(1, $urandom, $urandom, 1'($urandom), 0, 1);
    chk("bp_data", out_data, 32'hDEADBEEF);
    step(1, 32'h0BADF00D, 32'h600DCAFE, 1, 1, 1);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_ov", 32'(out_valid), 32'd0);
    step(0, '0, '0, 0, 1, 1);
    step(0, '0, '0, 0, 1, 1);
    chk("bp_new", out_data, 32'h600DCAFE);

    // back-to-back stream
    for (int i = 0; i < 13; i++)
      step(1, $urandom, $urandom, 1'($urandom), 1, 1);
    for (int i = 0; i < 4; i++)
      step(0, '0, '0, 0, 1, 1);

    // operand isolation while settling
    step(1, 32'hCAFEF00D, 32'h13579BDF, 0, 0, 1);
    step(1, 32'h11111111, 32'h22222222, 1, 0, 1);
    step(1, 32'h33333333, 32'h44444444, 0, 0, 1);
    chk("iso", out_data, 32'hCAFEF00D);
    step(0, '0, '0, 0, 1, 1);

    // reset mid-operation
    step(1, 32'h77777777, 32'h88888888, 1, 1, 1);
    step(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step(0, '0, '0, 0, 1, 1);
    chk("mid_rst_data", out_data, 32'd0);
    step(1, 32'h00000000, 32'hFFFFFFFF, 1, 1, 1);
    step(0, '0, '0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 1);
    chk("post_rst", out_data, 32'hFFFFFFFF);
    step(0, '0, '0, 0, 1, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, $urandom, $urandom,
           1'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
